// File: rtl/bit_clear_seq_pkg.sv
// Shared definitions for the slice-serial bit clear/set/toggle unit:
// operation encodings, FSM state type and default datapath geometry.
package bit_clear_seq_pkg;

   localparam logic [1:0] OP_CLEAR  = 2'b00;
   localparam logic [1:0] OP_SET    = 2'b01;
   localparam logic [1:0] OP_TOGGLE = 2'b10;
   localparam logic [1:0] OP_PASS   = 2'b11;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SLICE = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/bit_clear_seq_unit_bit_slice_op.sv
// Combinational SLICE-bit operator, shared by every slice of a word
// and time-multiplexed by the sequencer's slice counter.
module bit_slice_op
   import bit_clear_seq_pkg::*;
#(
   parameter int SLICE = DEF_SLICE
) (
   input  logic [SLICE-1:0] a,
   input  logic [SLICE-1:0] b,
   input  logic [1:0]       op,
   output logic [SLICE-1:0] y
);

   always_comb begin
      y = a;
      case (op)
         OP_CLEAR:  y = a & ~b;
         OP_SET:    y = a | b;
         OP_TOGGLE: y = a ^ b;
         default:   y = a;
      endcase
   end

endmodule

// File: rtl/bit_clear_seq_unit.sv
// Slice-serial bit clear/set/toggle/pass unit with start/done handshake.
// Optional zero flag on the result is enabled by BIT_CLEAR_SEQ_ZFLAG_EN.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | waiting for start; operands captured on acceptance
// ST_RUN  | one slice of result written per cycle, busy high
// ST_DONE | done pulse for one cycle, result complete
module bit_clear_seq_unit
   import bit_clear_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
   output logic             zero,
`endif
   output logic [WIDTH-1:0] result
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [1:0]       op_q;
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE-1:0] slice_y;

   assign slice_a = a_q[cnt*SLICE +: SLICE];
   assign slice_b = b_q[cnt*SLICE +: SLICE];

   bit_slice_op #(
      .SLICE (SLICE)
   ) u_slice (
      .a  (slice_a),
      .b  (slice_b),
      .op (op_q),
      .y  (slice_y)
   );

`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
   logic nz_acc;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ST_IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         op_q   <= OP_CLEAR;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
         nz_acc <= 1'b0;
         zero   <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_q   <= a;
                  b_q   <= b;
                  op_q  <= op;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= ST_RUN;
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
                  nz_acc <= 1'b0;
`endif
               end
            end
            ST_RUN: begin
               result[cnt*SLICE +: SLICE] <= slice_y;
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
               nz_acc <= nz_acc | (|slice_y);
`endif
               if (cnt == LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
                  // Fold in the last slice so the flag is valid alongside done.
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
                  zero  <= ~(nz_acc | (|slice_y));
`endif
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_clear_seq_unit.sv
// Directed self-checking bench for bit_clear_seq_unit with a result scoreboard.
// Define BIT_CLEAR_SEQ_ZFLAG_EN to also check the zero flag.
module tb_bit_clear_seq_unit;

   localparam int NSLICE = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic [31:0] result;
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
   logic        zero;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   bit_clear_seq_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
      .zero    (zero),
`endif
      .result  (result)
   );

   function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic [1:0] mop);
      case (mop)
         2'b00:   return ma & ~mb;
         2'b01:   return ma | mb;
         2'b10:   return ma ^ mb;
         default: return ma;
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Drive one start pulse, push the expected result, confirm acceptance.
   task automatic start_op(input logic [31:0] sa, input logic [31:0] sb, input logic [1:0] sop);
      a = sa; b = sb; op = sop; start = 1'b1;
      exp_q.push_back(model(sa, sb, sop));
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_accept", {31'b0, busy}, 32'd1);
   endtask

   // Wait for done (bounded), optionally re-pulsing start with other operands.
   task automatic wait_done(input int inject_at, input logic [31:0] ia,
                            input logic [31:0] ib, input logic [1:0] iop);
      int cyc = 0;
      int busy_cnt = 1;
      bit seen = 1'b0;
      logic [31:0] expv;
      for (int i = 1; i <= 20; i++) begin
         if (i == inject_at) begin
            a = ia; b = ib; op = iop; start = 1'b1;
         end
         @(posedge clk); #1;
         if (i == inject_at) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            cyc = i;
            seen = 1'b1;
            break;
         end
      end
      check("done_seen", {31'b0, seen}, 32'd1);
      check("done_latency", cyc, NSLICE);
      check("busy_cycles", busy_cnt, NSLICE);
      if (exp_q.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
         expv = 'x;
      end else begin
         expv = exp_q.pop_front();
      end
      check("result", result, expv);
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
      check("zero_flag", {31'b0, zero}, {31'b0, (expv == 32'd0)});
`endif
      @(posedge clk); #1;
      check("done_one_cycle", {31'b0, done}, 32'd0);
      check("idle_after_done", {31'b0, busy}, 32'd0);
   endtask

   initial begin
      int dones;
      int ndone;
      reset_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_done", {31'b0, done}, 32'd0);
      check("reset_result", result, 32'd0);
`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
      check("reset_zero", {31'b0, zero}, 32'd0);
`endif
      reset_n = 1'b1;
      @(posedge clk); #1;

      // CLEAR, SET, TOGGLE
      start_op(32'hFFFF_FFFF, 32'h0F0F_00FF, 2'b00);
      wait_done(0, '0, '0, 2'b00);
      check("clear_const", result, 32'hF0F0_FF00);
      start_op(32'h1234_0000, 32'h0000_ABCD, 2'b01);
      wait_done(0, '0, '0, 2'b00);
      start_op(32'h1234_0000, 32'h0000_ABCD, 2'b10);
      wait_done(0, '0, '0, 2'b00);
      start_op(32'hAAAA_AAAA, 32'hFFFF_FFFF, 2'b10);
      wait_done(0, '0, '0, 2'b00);
      check("toggle_const", result, 32'h5555_5555);
      start_op(32'hDEAD_BEEF, 32'h0000_0000, 2'b11);
      wait_done(0, '0, '0, 2'b00);

      // Start during RUN is ignored; operands stay captured
      start_op(32'h0123_4567, 32'hFF00_FF00, 2'b00);
      wait_done(3, 32'hFFFF_FFFF, 32'h0000_0000, 2'b01);
      check("ignored_start_result", result, 32'h0023_0067);
      repeat (3) @(posedge clk);
      #1;
      check("no_restart", {31'b0, busy}, 32'd0);

      // Reset in the middle of an operation
      start_op(32'hCAFE_F00D, 32'h0000_00FF, 2'b01);
      repeat (3) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("midrst_busy", {31'b0, busy}, 32'd0);
      check("midrst_done", {31'b0, done}, 32'd0);
      check("midrst_result", result, 32'd0);
      exp_q.delete();
      @(posedge clk); #2;
      reset_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("midrst_no_done", ndone, 0);
      start_op(32'h8000_0001, 32'h8000_0000, 2'b00);
      wait_done(0, '0, '0, 2'b00);

      // Back-to-back with start held high; fresh operands every cycle
      dones = 0;
      a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3)); start = 1'b1;
      for (int e = 0; e < 30; e++) begin
         if (e % 10 == 0) exp_q.push_back(model(a, b, op));
         @(posedge clk); #1;
         if (done) begin
            dones++;
            check("b2b_done_phase", e % 10, 8);
            if (exp_q.size() != 0) check("b2b_result", result, exp_q.pop_front());
            else check("b2b_scoreboard", 32'd0, 32'd1);
         end
         a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
      end
      start = 1'b0;
      check("b2b_count", dones, 3);
      exp_q.delete();
      repeat (12) @(posedge clk);
      #1;

`ifdef BIT_CLEAR_SEQ_ZFLAG_EN
      start_op(32'h0000_00F0, 32'h0000_00F0, 2'b00);
      wait_done(0, '0, '0, 2'b00);
      check("zflag_set", {31'b0, zero}, 32'd1);
      start_op(32'h0000_00F0, 32'h0000_00F0, 2'b11);
      wait_done(0, '0, '0, 2'b00);
      check("zflag_clr", {31'b0, zero}, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/bit_clear_seq_unit.md
Name: bit_clear_seq_unit

Overview:
- Multi-cycle bitwise unit for the MIPS datapath: the clearing counterpart of the OR datapath.
- The OR path sets bits (out = a | b). This block clears the selected bits (out = a & ~b) and can also apply a set or a toggle, on 32-bit operands.
- It processes SLICE bits per clock, so one narrow slice datapath is reused instead of replicating it across the full word.
- It sits beside the ALU and is started and completed by the control unit through a start/done handshake.

Parameters:
- WIDTH, 32, operand and result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per clock cycle.
- NSLICE, WIDTH/SLICE (8), derived: number of slices per operation; not overridable.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation select: 00 CLEAR (a & ~b), 01 SET (a | b), 10 TOGGLE (a ^ b), 11 PASS (a).
- a  input  WIDTH  source word.
- b  input  WIDTH  bit mask.
- busy  output  1  high while an operation is in progress.
- done  output  1  single-cycle pulse when result becomes valid.
- result  output  WIDTH  operation result; holds its value until the next operation completes.

Behaviour:
- Reset (async assert, reset_n low): state=IDLE, busy=0, done=0, result=0, slice counter=0, operand registers=0.
- Reset asserted mid-operation aborts it immediately. No done pulse is produced, and result returns to 0.
- FSM states and transitions:
  - IDLE: on start=1, capture a, b, op into internal registers; counter=0; go to RUN.
  - RUN: each cycle computes slice[counter] from the captured operands and writes it into result[counter*SLICE +: SLICE]. Then counter increments.
  - After writing slice NSLICE-1, go to DONE.
  - DONE: done=1 for exactly one cycle, busy=0; go to IDLE.
- busy=1 exactly while in RUN. It is asserted the cycle after start is accepted and lasts NSLICE cycles.
- Latency: start sampled at edge N gives done=1 during cycle N+NSLICE+1. Default: 9 cycles from start to done.
- start while in RUN or DONE is ignored. It is not queued.
- Input a, b, op changes after start is accepted have no effect; the operands are captured.
- Visibility of result:
  - result is updated slice by slice during RUN, so partial values are visible.
  - Consumers must sample result only at or after done.
  - Slices not yet written keep their previous-operation values.
- Counter width is clog2(NSLICE). It never wraps in RUN; the DONE transition occurs at NSLICE-1.
- Back-to-back operation: start held high in the cycle after done (in IDLE) is accepted. The maximum issue rate is one operation every NSLICE+2 cycles.

Optional Feature:
- Macro: BIT_CLEAR_SEQ_ZFLAG_EN.
- When defined:
  - Adds output port zero (1 bit, reset 0).
  - A sticky OR-accumulator tracks whether any written slice is non-zero. It is cleared on start acceptance.
  - zero is updated in DONE and equals 1 iff the final result == 0.
  - zero holds until the next DONE.
- When undefined: the port and the accumulator logic do not exist; all other behaviour is identical.

Decomposition:
- Shared package bit_clear_seq_pkg:
  - op encoding constants OP_CLEAR=2'b00, OP_SET=2'b01, OP_TOGGLE=2'b10, OP_PASS=2'b11.
  - FSM state typedef (IDLE, RUN, DONE).
  - Default WIDTH and SLICE constants.
- One natural sub-module, bit_slice_op: purely combinational, SLICE-bit a/b/op in, SLICE-bit out. It is instantiated once and time-multiplexed by the counter.

Test Plan:
- CLEAR: a=32'hFFFF_FFFF, b=32'h0F0F_00FF, op=00, start pulse -> busy high 8 cycles, done one cycle later, result=32'hF0F0_FF00.
- SET/TOGGLE:
  - a=32'h1234_0000, b=32'h0000_ABCD, op=01 -> result=32'h1234_ABCD.
  - Then, with the same a and b, op=10 -> result=32'h1234_ABCD.
  - Then a=32'hAAAA_AAAA, b=32'hFFFF_FFFF, op=10 -> result=32'h5555_5555.
- Ignored start and operand capture: start re-pulsed at RUN cycle 3 with different a/b -> no restart, done at the original cycle 9, result from the original operands.
- Mid-operation reset: reset_n low at RUN cycle 4 -> busy=0, done never pulses, result=0. A subsequent clean op completes normally.
- Back-to-back: start high continuously -> ops accepted every 10 cycles, and each result is correct for the operands present at its acceptance edge.
- ZFLAG (macro defined): a=32'h0000_00F0, b=32'h0000_00F0, op=00 -> result=0, zero=1. Then op=11 -> zero=0.
